dungeon_fsm: RTL and testbench
==============================

Name: dungeon_fsm

Overview:
Parametrised grid-dungeon game controller, the next generation of the fixed seven-room adventure game. The player moves around a GRID_W x GRID_H room grid using n/s/e/w. Items sit in configurable rooms and are collected on entry. Entering the dragon room ends the game in win if all items are held, otherwise in dead. An optional move budget also ends the game in dead when it is used up.

Parameters:
GRID_W, 3, grid columns (1..16)
GRID_H, 3, grid rows (1..16)
NUM_ITEMS, 1, number of collectible items (1..8)
ITEM_ROOMS, {8'd2}, packed NUM_ITEMS x 8-bit room indices; item k at bits [8k+7:8k]
START_ROOM, 0, room index after reset
DRAGON_ROOM, 8, dragon room index; must differ from START_ROOM and from every ITEM_ROOMS entry
MOVE_LIMIT, 0, accepted-move budget; 0 = unlimited

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
n  in  1  move north (row-1), level-sampled
s  in  1  move south (row+1)
e  in  1  move east (col+1)
w  in  1  move west (col-1)
room  out  GRID_W*GRID_H  one-hot current room; bit index = row*GRID_W+col
items  out  NUM_ITEMS  collected-item flags
moves  out  8  accepted-move count, saturating at 255
win  out  1  game won, held until reset
dead  out  1  game lost, held until reset

Behaviour:
- Reset (async, immediate):
  - position = START_ROOM, so room = one-hot(START_ROOM)
  - items = 0, moves = 0, win = 0, dead = 0
  - state = PLAY
- States:
  - PLAY: normal play; transitions to WIN or DEAD as below.
  - WIN: absorbing; all inputs ignored until reset.
  - DEAD: absorbing; all inputs ignored until reset.
- Move acceptance (PLAY only):
  - A move is a rising clk edge where exactly one of n/s/e/w is 1.
  - Zero or two or more asserted directions = no action.
  - The bench/debouncer delivers one-cycle pulses.
- Walls: a move that would leave the grid (row 0 north, row GRID_H-1 south, col 0 west, col GRID_W-1 east) is blocked.
  - Position is unchanged and moves does not increment.
- Accepted move: position updates and moves increments on the same edge. All outputs are registered, so latency is 1 cycle from sampled input to new room/items/win/dead.
- Item pickup: on the edge that enters a room equal to ITEM_ROOMS[k], items[k] is set. It stays set until reset. Revisiting has no effect.
- Dragon: on the edge entering DRAGON_ROOM:
  - If items are all 1 (pre-move value), state becomes WIN and win = 1.
  - Otherwise state becomes DEAD and dead = 1.
  - room still shows DRAGON_ROOM.
- Move limit (MOVE_LIMIT != 0): if an accepted move makes moves == MOVE_LIMIT and the target is not DRAGON_ROOM, state becomes DEAD.
  - If the limit-reaching move enters DRAGON_ROOM, the dragon rule decides the outcome (a win is possible on the last move).
- win and dead are never both 1.
- Reset mid-game: returns immediately to reset values regardless of state.

Decomposition:
- Package dungeon_pkg holds:
  - game_state_t enum {PLAY, WIN, DEAD}
  - dir_t encoding
  - function room_idx(row, col, GRID_W)
  - localparam IDX_W = $clog2(GRID_W*GRID_H)
- One sub-module, item_tracker: the generalised sword register.
  - Inputs: clk, reset, enter_valid, enter_room, ITEM_ROOMS.
  - Outputs: items and all_items.
- The top holds the position registers, move counter and state FSM.

Test Plan:
- Win path, defaults: reset, then e,e,s,s one per cycle.
  - After e,e: room bit 2 set, items = 1.
  - After s,s: room bit 8 set, win = 1, dead = 0, moves = 4.
- Death path: reset, then s,s,e,e.
  - After the 4th move: dead = 1, win = 0, items = 0, room bit 8 set.
  - Further e/w pulses leave room and moves = 4 unchanged.
- Walls and invalid input, from reset:
  - n -> room bit 0 unchanged, moves = 0.
  - w -> room bit 0 unchanged, moves = 0.
  - n+e together -> no change.
  - e -> room bit 1 set, moves = 1.
- Move limit (MOVE_LIMIT = 4): e,w,e,w -> after the 4th move dead = 1, room bit 0 set, moves = 4.
- Limit vs dragon (MOVE_LIMIT = 4): e,e,s,s -> win = 1, dead = 0; the dragon rule takes priority on the limit-reaching move.
- Async reset mid-game: after e,e,s, assert reset between clk edges.
  - room = bit 0, items = 0, moves = 0 immediately, without waiting for a clock edge.
  - After release, e,e,s,s again wins.

Source files
------------

// File: rtl/dungeon_pkg.sv
// Shared types and helpers for the grid-dungeon game controller.
// Room indices are carried at a fixed 8-bit width so that any legal grid (up to 16x16) fits.
package dungeon_pkg;

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        DEAD
    } game_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_N,
        DIR_S,
        DIR_E,
        DIR_W,
        DIR_MULTI
    } dir_t;

    localparam int MAX_ROOMS = 16 * 16;
    localparam int IDX_W     = $clog2(MAX_ROOMS);

    function automatic logic [IDX_W-1:0] room_idx(input logic [7:0] row,
                                                  input logic [7:0] col,
                                                  input int         gridW);
        int flat;
        flat = int'(row) * gridW + int'(col);
        return flat[IDX_W-1:0];
    endfunction

    // Only a single asserted direction counts as a move; anything else is ignored.
    function automatic dir_t decode_dir(input logic dn, input logic ds,
                                        input logic de, input logic dw);
        dir_t result;
        case ({dn, ds, de, dw})
            4'b0000: result = DIR_NONE;
            4'b1000: result = DIR_N;
            4'b0100: result = DIR_S;
            4'b0010: result = DIR_E;
            4'b0001: result = DIR_W;
            default: result = DIR_MULTI;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dungeon_fsm_item_tracker.sv
// Sticky collected-item flags: each item is taken on the edge that enters its room.
// all_items reflects the flags before the current edge, which the dragon rule relies on.
module item_tracker
#(
    parameter int                     NUM_ITEMS  = 1,
    parameter logic [8*NUM_ITEMS-1:0] ITEM_ROOMS = 8'd2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enter_valid,
    input  logic [dungeon_pkg::IDX_W-1:0] enter_room,
    output logic [NUM_ITEMS-1:0]         items,
    output logic                         all_items
);
    import dungeon_pkg::*;

    logic [NUM_ITEMS-1:0] r_items;
    logic [NUM_ITEMS-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            w_hit[k] = enter_valid && (enter_room == ITEM_ROOMS[8*k +: IDX_W]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_items <= '0;
        end else begin
            r_items <= r_items | w_hit;
        end
    end

    assign items     = r_items;
    assign all_items = &r_items;

endmodule

// File: rtl/dungeon_fsm.sv
// Grid-dungeon controller: position registers, saturating move counter and PLAY/WIN/DEAD FSM.
// A move is a clock edge with exactly one direction asserted that does not cross a wall.
module dungeon_fsm
#(
    parameter int                     GRID_W      = 3,
    parameter int                     GRID_H      = 3,
    parameter int                     NUM_ITEMS   = 1,
    parameter logic [8*NUM_ITEMS-1:0] ITEM_ROOMS  = 8'd2,
    parameter int                     START_ROOM  = 0,
    parameter int                     DRAGON_ROOM = 8,
    parameter int                     MOVE_LIMIT  = 0
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       n,
    input  logic                       s,
    input  logic                       e,
    input  logic                       w,
    output logic [GRID_W*GRID_H-1:0]   room,
    output logic [NUM_ITEMS-1:0]       items,
    output logic [7:0]                 moves,
    output logic                       win,
    output logic                       dead
);
    import dungeon_pkg::*;

    localparam int              NUM_ROOMS  = GRID_W * GRID_H;
    localparam logic [3:0]      START_ROW  = 4'(START_ROOM / GRID_W);
    localparam logic [3:0]      START_COL  = 4'(START_ROOM % GRID_W);
    localparam logic [3:0]      LAST_ROW   = 4'(GRID_H - 1);
    localparam logic [3:0]      LAST_COL   = 4'(GRID_W - 1);
    localparam logic [IDX_W-1:0] DRAGON_IDX = 8'(DRAGON_ROOM);

    game_state_t      r_state;
    game_state_t      w_nextState;
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic [7:0]       r_moves;

    dir_t             w_dir;
    logic [3:0]       w_tgtRow;
    logic [3:0]       w_tgtCol;
    logic             w_canMove;
    logic [IDX_W-1:0] w_tgtIdx;
    logic [IDX_W-1:0] w_curIdx;
    logic [7:0]       w_movesInc;
    logic             w_hitDragon;
    logic             w_limitHit;
    logic             w_allItems;

    // Target cell, wall blocking and end-of-game decision; the dragon outranks the move limit.
    always_comb begin
        w_dir       = decode_dir(n, s, e, w);
        w_tgtRow    = r_row;
        w_tgtCol    = r_col;
        w_canMove   = 1'b0;
        if (r_state == PLAY) begin
            case (w_dir)
                DIR_N: if (r_row != 4'd0) begin
                    w_tgtRow  = r_row - 4'd1;
                    w_canMove = 1'b1;
                end
                DIR_S: if (r_row != LAST_ROW) begin
                    w_tgtRow  = r_row + 4'd1;
                    w_canMove = 1'b1;
                end
                DIR_E: if (r_col != LAST_COL) begin
                    w_tgtCol  = r_col + 4'd1;
                    w_canMove = 1'b1;
                end
                DIR_W: if (r_col != 4'd0) begin
                    w_tgtCol  = r_col - 4'd1;
                    w_canMove = 1'b1;
                end
                default: ;
            endcase
        end
        w_tgtIdx    = room_idx(8'(w_tgtRow), 8'(w_tgtCol), GRID_W);
        w_movesInc  = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;
        w_hitDragon = w_canMove && (w_tgtIdx == DRAGON_IDX);
        w_limitHit  = w_canMove && (MOVE_LIMIT != 0) && (int'(w_movesInc) == MOVE_LIMIT);
        w_nextState = r_state;
        if (w_hitDragon) begin
            w_nextState = w_allItems ? WIN : DEAD;
        end else if (w_limitHit) begin
            w_nextState = DEAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PLAY;
            r_row   <= START_ROW;
            r_col   <= START_COL;
            r_moves <= 8'd0;
        end else begin
            r_state <= w_nextState;
            if (w_canMove) begin
                r_row   <= w_tgtRow;
                r_col   <= w_tgtCol;
                r_moves <= w_movesInc;
            end
        end
    end

    item_tracker #(
        .NUM_ITEMS  (NUM_ITEMS),
        .ITEM_ROOMS (ITEM_ROOMS)
    ) u_items (
        .clk         (clk),
        .reset       (reset),
        .enter_valid (w_canMove),
        .enter_room  (w_tgtIdx),
        .items       (items),
        .all_items   (w_allItems)
    );

    always_comb begin
        w_curIdx = room_idx(8'(r_row), 8'(r_col), GRID_W);
        room     = '0;
        for (int i = 0; i < NUM_ROOMS; i++) begin
            room[i] = (w_curIdx == i[IDX_W-1:0]);
        end
    end

    assign moves = r_moves;
    assign win   = (r_state == WIN);
    assign dead  = (r_state == DEAD);

endmodule

// File: tb/tb_dungeon_fsm.sv
// Self-checking bench for dungeon_fsm: two instances (unlimited and MOVE_LIMIT=4) share stimulus,
// checked against a hand-written vector table, a mid-game async reset and a random walk vs a model.
module tb_dungeon_fsm;

    localparam int GW    = 3;
    localparam int GH    = 3;
    localparam int ITEM  = 2;
    localparam int DRAG  = 8;
    localparam int START = 0;

    localparam logic [3:0] N_ = 4'b1000;
    localparam logic [3:0] S_ = 4'b0100;
    localparam logic [3:0] E_ = 4'b0010;
    localparam logic [3:0] W_ = 4'b0001;

    logic       clk;
    logic       reset;
    logic       n, s, e, w;
    logic [8:0] roomA, roomB;
    logic [0:0] itemsA, itemsB;
    logic [7:0] movesA, movesB;
    logic       winA, deadA, winB, deadB;

    int checks;
    int failures;

    // Model state, index 0 = unlimited instance, 1 = MOVE_LIMIT=4 instance; outcome 0 play, 1 win, 2 dead
    int mRow[2];
    int mCol[2];
    int mMoves[2];
    int mOut[2];
    bit mHeld[2];
    int limits[2];

    typedef struct {
        bit         doReset;
        logic [3:0] nsew;
        string      tag;
        int         items;
        int         roomA, movesA, winA, deadA;
        int         roomB, movesB, winB, deadB;
    } vec_t;

    vec_t vecs[$];

    dungeon_fsm dutA (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(roomA), .items(itemsA), .moves(movesA), .win(winA), .dead(deadA)
    );

    dungeon_fsm #(.MOVE_LIMIT(4)) dutB (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(roomB), .items(itemsB), .moves(movesB), .win(winB), .dead(deadB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mRow[k]   = START / GW;
            mCol[k]   = START % GW;
            mMoves[k] = 0;
            mOut[k]   = 0;
            mHeld[k]  = 1'b0;
        end
    endtask

    task automatic modelStep(input logic [3:0] nsew);
        for (int k = 0; k < 2; k++) begin
            int nr;
            int nc;
            int idx;
            bit wasAll;
            if (mOut[k] != 0) continue;
            if ($countones(nsew) != 1) continue;
            nr = mRow[k];
            nc = mCol[k];
            if (nsew[3]) nr = nr - 1;
            if (nsew[2]) nr = nr + 1;
            if (nsew[1]) nc = nc + 1;
            if (nsew[0]) nc = nc - 1;
            if (nr < 0 || nr >= GH || nc < 0 || nc >= GW) continue;
            mRow[k]   = nr;
            mCol[k]   = nc;
            mMoves[k] = (mMoves[k] < 255) ? mMoves[k] + 1 : 255;
            idx       = nr * GW + nc;
            wasAll    = mHeld[k];
            if (idx == ITEM) mHeld[k] = 1'b1;
            if (idx == DRAG) mOut[k] = wasAll ? 1 : 2;
            else if (limits[k] != 0 && mMoves[k] == limits[k]) mOut[k] = 2;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input logic [3:0] nsew);
        @(negedge clk);
        {n, s, e, w} = nsew;
        @(posedge clk);
        #1;
        {n, s, e, w} = 4'b0000;
        modelStep(nsew);
    endtask

    task automatic addVec(input bit rst, input logic [3:0] nsew, input string tag, input int items,
                          input int rA, input int mA, input int wA, input int dA,
                          input int rB, input int mB, input int wB, input int dB);
        vec_t v;
        v.doReset = rst;  v.nsew   = nsew;  v.tag  = tag;  v.items = items;
        v.roomA   = rA;   v.movesA = mA;    v.winA = wA;   v.deadA = dA;
        v.roomB   = rB;   v.movesB = mB;    v.winB = wB;   v.deadB = dB;
        vecs.push_back(v);
    endtask

    task automatic checkVec(input vec_t v);
        checkOutput({v.tag, " roomA"},  int'(roomA),  1 << v.roomA);
        checkOutput({v.tag, " movesA"}, int'(movesA), v.movesA);
        checkOutput({v.tag, " itemsA"}, int'(itemsA), v.items);
        checkOutput({v.tag, " winA"},   int'(winA),   v.winA);
        checkOutput({v.tag, " deadA"},  int'(deadA),  v.deadA);
        checkOutput({v.tag, " roomB"},  int'(roomB),  1 << v.roomB);
        checkOutput({v.tag, " movesB"}, int'(movesB), v.movesB);
        checkOutput({v.tag, " itemsB"}, int'(itemsB), v.items);
        checkOutput({v.tag, " winB"},   int'(winB),   v.winB);
        checkOutput({v.tag, " deadB"},  int'(deadB),  v.deadB);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " roomA"},  int'(roomA),  1 << (mRow[0] * GW + mCol[0]));
        checkOutput({tag, " movesA"}, int'(movesA), mMoves[0]);
        checkOutput({tag, " itemsA"}, int'(itemsA), int'(mHeld[0]));
        checkOutput({tag, " winA"},   int'(winA),   int'(mOut[0] == 1));
        checkOutput({tag, " deadA"},  int'(deadA),  int'(mOut[0] == 2));
        checkOutput({tag, " roomB"},  int'(roomB),  1 << (mRow[1] * GW + mCol[1]));
        checkOutput({tag, " movesB"}, int'(movesB), mMoves[1]);
        checkOutput({tag, " itemsB"}, int'(itemsB), int'(mHeld[1]));
        checkOutput({tag, " winB"},   int'(winB),   int'(mOut[1] == 1));
        checkOutput({tag, " deadB"},  int'(deadB),  int'(mOut[1] == 2));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        limits[0] = 0;
        limits[1] = 4;
        reset     = 1'b1;
        {n, s, e, w} = 4'b0000;
        modelReset();
        #12;
        reset = 1'b0;

        //     rst nsew  tag           it rA mA wA dA  rB mB wB dB
        addVec(1, 4'b0, "win rst",      0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, E_,   "win e1",       0, 1, 1, 0, 0,  1, 1, 0, 0);
        addVec(0, E_,   "win e2",       1, 2, 2, 0, 0,  2, 2, 0, 0);
        addVec(0, S_,   "win s1",       1, 5, 3, 0, 0,  5, 3, 0, 0);
        addVec(0, S_,   "win s2",       1, 8, 4, 1, 0,  8, 4, 1, 0);
        addVec(0, W_,   "win hold",     1, 8, 4, 1, 0,  8, 4, 1, 0);
        addVec(1, 4'b0, "death rst",    0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, S_,   "death s1",     0, 3, 1, 0, 0,  3, 1, 0, 0);
        addVec(0, S_,   "death s2",     0, 6, 2, 0, 0,  6, 2, 0, 0);
        addVec(0, E_,   "death e1",     0, 7, 3, 0, 0,  7, 3, 0, 0);
        addVec(0, E_,   "death e2",     0, 8, 4, 0, 1,  8, 4, 0, 1);
        addVec(0, E_,   "death hold e", 0, 8, 4, 0, 1,  8, 4, 0, 1);
        addVec(0, W_,   "death hold w", 0, 8, 4, 0, 1,  8, 4, 0, 1);
        addVec(1, 4'b0, "wall rst",     0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, N_,   "wall n",       0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, W_,   "wall w",       0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, N_|E_, "multi ne",    0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, S_|W_, "multi sw",    0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, E_,   "wall e ok",    0, 1, 1, 0, 0,  1, 1, 0, 0);
        addVec(1, 4'b0, "limit rst",    0, 0, 0, 0, 0,  0, 0, 0, 0);
        addVec(0, E_,   "limit e1",     0, 1, 1, 0, 0,  1, 1, 0, 0);
        addVec(0, W_,   "limit w1",     0, 0, 2, 0, 0,  0, 2, 0, 0);
        addVec(0, E_,   "limit e2",     0, 1, 3, 0, 0,  1, 3, 0, 0);
        addVec(0, W_,   "limit w2",     0, 0, 4, 0, 0,  0, 4, 0, 1);
        addVec(0, E_,   "limit after",  0, 1, 5, 0, 0,  0, 4, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) begin
                doReset();
                #1;
            end else begin
                applyStimulus(vecs[i].nsew);
            end
            checkVec(vecs[i]);
        end

        // Asynchronous reset in the middle of a game, asserted between clock edges.
        doReset();
        applyStimulus(E_);
        applyStimulus(E_);
        applyStimulus(S_);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async roomA",  int'(roomA),  1);
        checkOutput("async itemsA", int'(itemsA), 0);
        checkOutput("async movesA", int'(movesA), 0);
        checkOutput("async roomB",  int'(roomB),  1);
        checkOutput("async movesB", int'(movesB), 0);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(E_);
        applyStimulus(E_);
        applyStimulus(S_);
        applyStimulus(S_);
        checkOutput("rewin winA",   int'(winA),   1);
        checkOutput("rewin deadA",  int'(deadA),  0);
        checkOutput("rewin movesA", int'(movesA), 4);
        checkOutput("rewin winB",   int'(winB),   1);

        // Random walk compared every cycle with the behavioural model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] nsew;
            if ($urandom_range(0, 9) < 7) nsew = 4'b0001 << $urandom_range(0, 3);
            else nsew = 4'($urandom_range(0, 15));
            applyStimulus(nsew);
            checkModel("rnd");
            if (mOut[0] != 0 && mOut[1] != 0 && $urandom_range(0, 2) == 0) begin
                doReset();
                #1;
                checkModel("rnd rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
